systolic_2x2_ctrl: RTL and testbench

//  Sequencer for the 2x2 systolic matmul array: accepts one A/B operand pair, clears the PE

---
 rtl/systolic_2x2_ctrl.sv | 158 +++++++++++++++
 tb/tb_systolic_2x2_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_2x2_ctrl.sv
// Sequencer for a 2x2 systolic matmul array: clears PEs, streams skewed operands, captures C.
// Optional job counter port is enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_2x2_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DATA_W-1:0]   in_a,
  input  logic [4*DATA_W-1:0]   in_b,
  output logic                  pe_clear,
  output logic [DATA_W-1:0]     a_row0,
  output logic [DATA_W-1:0]     a_row1,
  output logic [DATA_W-1:0]     b_col0,
  output logic [DATA_W-1:0]     b_col1,
  input  logic [ACC_W-1:0]      c00,
  input  logic [ACC_W-1:0]      c01,
  input  logic [ACC_W-1:0]      c10,
  input  logic [ACC_W-1:0]      c11,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4*ACC_W-1:0]    res_c,
  output logic                  busy
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [15:0]           job_cnt
`endif
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StFeed  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [4*DATA_W-1:0] op_a_q, op_a_d;
  logic [4*DATA_W-1:0] op_b_q, op_b_d;
  logic [4*ACC_W-1:0]  res_c_q, res_c_d;

  logic [DATA_W-1:0] a00, a01, a10, a11, b00, b01, b10, b11;

  assign a00 = op_a_q[0*DATA_W +: DATA_W];
  assign a01 = op_a_q[1*DATA_W +: DATA_W];
  assign a10 = op_a_q[2*DATA_W +: DATA_W];
  assign a11 = op_a_q[3*DATA_W +: DATA_W];
  assign b00 = op_b_q[0*DATA_W +: DATA_W];
  assign b01 = op_b_q[1*DATA_W +: DATA_W];
  assign b10 = op_b_q[2*DATA_W +: DATA_W];
  assign b11 = op_b_q[3*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_c_d = res_c_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          state_d = StClear;
        end
      end
      StClear: begin
        cnt_d   = 3'd0;
        state_d = StFeed;
      end
      StFeed: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd2) state_d = StDrain;
      end
      StDrain: begin
        // Last drain cycle: PE(1,1) has absorbed its final product one cycle earlier.
        if (cnt_q == 3'd4) begin
          res_c_d = {c11, c10, c01, c00};
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_c_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_c_q <= res_c_d;
    end
  end

  // Feeds are pure decodes of registered state, counter and operands.
  always_comb begin
    a_row0 = '0;
    a_row1 = '0;
    b_col0 = '0;
    b_col1 = '0;
    if (state_q == StFeed) begin
      unique case (cnt_q)
        3'd0: begin
          a_row0 = a00;
          b_col0 = b00;
        end
        3'd1: begin
          a_row0 = a01;
          a_row1 = a10;
          b_col0 = b10;
          b_col1 = b01;
        end
        3'd2: begin
          a_row1 = a11;
          b_col1 = b11;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign pe_clear  = (state_q == StClear);
  assign res_valid = (state_q == StDone);
  assign res_c     = res_c_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0] job_cnt_q, job_cnt_d;

  always_comb begin
    job_cnt_d = job_cnt_q;
    if ((state_q == StDone) && res_ready) job_cnt_d = job_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) job_cnt_q <= 16'd0;
    else        job_cnt_q <= job_cnt_d;
  end

  assign job_cnt = job_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_2x2_ctrl.sv
// Bench for systolic_2x2_ctrl: behavioural PE array, matrix-level reference model, vector table.
module tb_systolic_2x2_ctrl;

  localparam int DW = 8;
  localparam int AW = 18;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4*DW-1:0]   in_a = '0;
  logic [4*DW-1:0]   in_b = '0;
  logic              pe_clear;
  logic [DW-1:0]     a_row0, a_row1, b_col0, b_col1;
  logic [AW-1:0]     c00, c01, c10, c11;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [4*AW-1:0]   res_c;
  logic              busy;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0]       job_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  systolic_2x2_ctrl #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .pe_clear  (pe_clear),
    .a_row0    (a_row0),
    .a_row1    (a_row1),
    .b_col0    (b_col0),
    .b_col1    (b_col1),
    .c00       (c00),
    .c01       (c01),
    .c10       (c10),
    .c11       (c11),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_c     (res_c),
    .busy      (busy)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .job_cnt   (job_cnt)
`endif
  );

  // Environment: 2x2 output-stationary PE array, operands forwarded right/down each cycle.
  logic signed [DW-1:0] a_pass0, a_pass1, b_pass0, b_pass1;
  logic signed [AW-1:0] acc00, acc01, acc10, acc11;
  assign c00 = acc00;
  assign c01 = acc01;
  assign c10 = acc10;
  assign c11 = acc11;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || pe_clear) begin
      acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
      a_pass0 <= '0; a_pass1 <= '0; b_pass0 <= '0; b_pass1 <= '0;
    end else begin
      acc00   <= acc00 + AW'($signed(a_row0) * $signed(b_col0));
      acc01   <= acc01 + AW'(a_pass0 * $signed(b_col1));
      acc10   <= acc10 + AW'($signed(a_row1) * b_pass0);
      acc11   <= acc11 + AW'(a_pass1 * b_pass1);
      a_pass0 <= $signed(a_row0);
      a_pass1 <= $signed(a_row1);
      b_pass0 <= $signed(b_col0);
      b_pass1 <= $signed(b_col1);
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [4*DW-1:0] pack_op(input int x0, input int x1, input int x2,
                                              input int x3);
    return {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
  endfunction

  function automatic logic [4*AW-1:0] pack_c(input int x0, input int x1, input int x2,
                                             input int x3);
    return {AW'(x3), AW'(x2), AW'(x1), AW'(x0)};
  endfunction

  // Element (i,k) of a 2x2 matrix packed in lane order 00 01 10 11.
  function automatic int el(input logic [4*DW-1:0] m, input int i, input int k);
    logic signed [DW-1:0] v;
    v = m[(2*i+k)*DW +: DW];
    return int'(v);
  endfunction

  function automatic logic [4*AW-1:0] matmul(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
    logic [4*AW-1:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        r[(2*i+j)*AW +: AW] = AW'(el(a, i, 0) * el(b, 0, j) + el(a, i, 1) * el(b, 1, j));
    return r;
  endfunction

  // Row i carries A[i][k] at step i+k; column j carries B[k][j] at step j+k.
  function automatic logic [4*DW-1:0] feeds(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                                            input int t);
    logic [DW-1:0] r [2];
    logic [DW-1:0] c [2];
    for (int n = 0; n < 2; n++) begin
      r[n] = '0;
      c[n] = '0;
      if (t - n >= 0 && t - n <= 1) begin
        r[n] = DW'(el(a, n, t - n));
        c[n] = DW'(el(b, t - n, n));
      end
    end
    return {r[0], r[1], c[0], c[1]};
  endfunction

  task automatic do_job(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                        input logic [4*AW-1:0] expc, input int hold);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_wait", in_ready, 1'b1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    cyc = 1;
    while (!res_valid && cyc < 20) begin
      chk("pe_clear", pe_clear, cyc == 1);
      chk("feeds", {a_row0, a_row1, b_col0, b_col1}, (cyc >= 2) ? feeds(a, b, cyc - 2) : '0);
      chk("busy_run", {busy, in_ready}, 2'b10);
      res_ready = (cyc < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", cyc, 7);
    chk("res_c", res_c, expc);
    chk("done_ready", in_ready, 1'b0);
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = $urandom;
      @(negedge clk);
      chk("hold_valid", {res_valid, in_ready, busy}, 3'b101);
      chk("hold_res_c", res_c, expc);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("after_hs", {res_valid, in_ready, busy}, 3'b010);
  endtask

  typedef struct {
    logic [4*DW-1:0] a;
    logic [4*DW-1:0] b;
    logic [4*AW-1:0] c;
    int              hold;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            vecs [4];
    logic [4*DW-1:0] ra, rb;
    logic [4*DW-1:0] qa [$];
    logic [4*DW-1:0] qb [$];

    vecs[0] = '{pack_op(1, 2, 3, 4), pack_op(5, 6, 7, 8), pack_c(19, 22, 43, 50), 0};
    vecs[1] = '{pack_op(-128, -128, -128, -128), pack_op(-128, -128, -128, -128),
                pack_c(32768, 32768, 32768, 32768), 1};
    vecs[2] = '{pack_op(1, 0, 0, 1), pack_op(-3, 4, 5, -6), pack_c(-3, 4, 5, -6), 0};
    vecs[3] = '{pack_op(1, 2, 3, 4), pack_op(5, 6, 7, 8), pack_c(19, 22, 43, 50), 10};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {pe_clear, res_valid, busy, a_row0, a_row1, b_col0, b_col1, res_c},
        '0);
    chk("reset_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) do_job(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].hold);

    // Reset during FEED t1 discards the job.
    in_valid = 1'b1;
    in_a = vecs[0].a;
    in_b = vecs[0].b;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_feed_pre_rst", {a_row0, a_row1, b_col0, b_col1}, feeds(vecs[0].a, vecs[0].b, 1));
    rst_n = 1'b0;
    #1;
    chk("rst_outs", {pe_clear, res_valid, busy, a_row0, a_row1, b_col0, b_col1, res_c}, '0);
    chk("rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_idle", {res_valid, busy, in_ready}, 3'b001);
    end
    do_job(vecs[0].a, vecs[0].b, vecs[0].c, 0);

    // Back-to-back jobs with in_valid held and res_ready tied high.
    in_valid = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      chk("b2b_ready", in_ready, (i % 8) == 0);
      chk("b2b_busy", busy, (i % 8) != 0);
      chk("b2b_valid", res_valid, (i % 8) == 7);
      if (i % 8 == 0) begin
        in_a = $urandom;
        in_b = $urandom;
        qa.push_back(in_a);
        qb.push_back(in_b);
      end
      if (i % 8 == 7 && qa.size() > 0) chk("b2b_res_c", res_c, matmul(qa.pop_front(),
                                                                        qb.pop_front()));
      if (i == 39) in_valid = 1'b0;
      @(negedge clk);
    end
    res_ready = 1'b0;
    chk("b2b_end_idle", {in_ready, busy}, 2'b10);

    for (int n = 0; n < 12; n++) begin
      ra = $urandom;
      rb = $urandom;
      do_job(ra, rb, matmul(ra, rb), $urandom_range(0, 3));
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("job_cnt_rst", job_cnt, 16'd0);
    for (int n = 0; n < 3; n++) do_job(vecs[0].a, vecs[0].b, vecs[0].c, n);
    chk("job_cnt_3", job_cnt, 16'd3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("job_cnt_clr", job_cnt, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
